display_arbiter: RTL and testbench
==================================

Name: display_arbiter

Overview:
Shares the 4-digit seven-segment display between up to NUM_REQ requesters, such as per-button bounce counters or status sources, each offering a 16-bit hex value.
- Round-robin arbitration with a minimum on-screen hold time.
- Drives the digits and decimal_points inputs of seven_seg_controller.
- Lit decimal point marks which requester is shown.
- Sits between the counter/datapath blocks and the display controller in the board top level.

Parameters:
NUM_REQ, 4, number of requesters (2..4; one decimal point per requester)
HOLD_CYCLES, 50000000, minimum clk cycles a granted source stays on screen (>=1)
HOLD_WIDTH, 26, width of hold counter; must satisfy 2^HOLD_WIDTH > HOLD_CYCLES
IDLE_PATTERN, 16'h0000, digits value shown when nothing is granted

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester display request, level-sensitive
data  input  16*NUM_REQ  requester i value on data[16*i+15:16*i]
grant  output  NUM_REQ  one-hot grant, all-zero when idle
digits  output  16  value to seven_seg_controller, registered
decimal_points  output  4  bit i set when requester i is granted, registered
active_idx  output  2  index of granted requester, valid when grant!=0

Behaviour:
- One clock (clk). Reset is synchronous and active-high (port reset). All state changes on the rising clk edge.
- Reset values: state=IDLE, grant=0, digits=IDLE_PATTERN, decimal_points=0, active_idx=0, hold counter=0, last pointer=NUM_REQ-1 (so requester 0 has first priority).
- States: IDLE, SHOW.
- IDLE:
  - If req==0, stay in IDLE; outputs hold their reset values.
  - If any req is set, pick the winner by round-robin from last+1 (mod NUM_REQ).
  - Next edge: enter SHOW, grant=onehot(winner), active_idx=winner, last=winner, hold counter=HOLD_CYCLES-1, digits=data[winner], decimal_points=onehot(winner).
  - Latency from req to grant/digits is 1 cycle.
- SHOW, hold counter != 0:
  - Decrement the counter.
  - While req[active_idx]=1, register digits<=data[active_idx] every cycle (1-cycle latency).
  - While req[active_idx]=0, digits are frozen at the last sampled value. The grant is kept; no early release.
  - Other requests are ignored until the hold expires.
- SHOW, hold counter == 0 (expiry): re-arbitrate over the current req vector from last+1.
  - Winner exists, whether the same or another requester: grant it as in IDLE, reload counter to HOLD_CYCLES-1. Grant switches with no idle gap.
  - The same requester is re-granted only when no other req is set, so the display never starves a waiting requester beyond one hold period per competitor.
  - No req set: next edge IDLE, grant=0, digits=IDLE_PATTERN, decimal_points=0.
- HOLD_CYCLES=1: re-arbitration happens every cycle.
- Requests on bits >= NUM_REQ do not exist; decimal_points bits >= NUM_REQ are always 0.
- Reset asserted in any state, mid-hold or mid-switch: next edge applies reset values; the pointer returns to NUM_REQ-1.
- Invariant: grant is one-hot or zero. decimal_points[NUM_REQ-1:0] == grant at all times.

Decomposition:
- Shared header display_defs.vh: state encodings (ST_IDLE, ST_SHOW), DIGITS_W=16, DP_W=4.
- Sub-module rr_picker: combinational round-robin selector.
  - Inputs: req vector, last pointer.
  - Outputs: found flag, winner index.
- The hold timer stays inline in display_arbiter, as a loadable down-counter.

Test Plan:
All scenarios run with NUM_REQ=4, HOLD_CYCLES=4.
1. Reset held 3 cycles with req=4'b1111 -> grant=0, digits=16'h0000, decimal_points=0 throughout; after release, grant=4'b0001 one cycle later.
2. req=4'b0010, data1=16'h1234, held 20 cycles -> grant=4'b0010 and digits=16'h1234 after 1 cycle, decimal_points=4'b0010; grant never drops; changing data1 to 16'hBEEF shows on digits exactly 1 cycle later.
3. req=4'b0101 held, data0=16'h0A0A, data2=16'h2C2C -> grant alternates 0001/0100 every 4 cycles, first 0001; digits track the granted source; no cycle with grant=0.
4. Single req1 granted, req1 dropped 1 cycle after grant -> digits frozen at last value until hold expiry, then IDLE: grant=0, digits=16'h0000.
5. Requester 3 granted, req0 raised 1 cycle later -> req0 is not granted until the hold expires (4 cycles after grant); then grant=4'b0001 with no gap.
6. Reset pulsed for 1 cycle while granted to requester 2 with req=4'b0101 -> next edge all reset values; one cycle after release grant=4'b0001.

Source files
------------

// File: rtl/display_arbiter_pkg.sv
// display_arbiter_pkg: shared state encoding and display widths for the display arbiter.
package display_arbiter_pkg;
  typedef enum logic {ST_IDLE, ST_SHOW} state_t;
  localparam int DIGITS_W = 16;
  localparam int DP_W = 4;
endpackage

// File: rtl/display_arbiter_rr_picker.sv
// display_arbiter_rr_picker: combinational round-robin selector starting after the last winner.
module display_arbiter_rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic               found,
  output logic [1:0]         idx
);
  logic [1:0] c;
  always_comb begin
    found = |req;
    idx = '0;
    c = '0;
    // Scan farthest-first so the nearest request after last wins the final assignment.
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = 2'((int'(last) + k) % NUM_REQ);
      if (req[c]) idx = c;
    end
  end
endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin sharing of the 4-digit display with a minimum hold time per source.
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter int             NUM_REQ      = 4,
  parameter int             HOLD_CYCLES  = 50000000,
  parameter int             HOLD_WIDTH   = 26,
  parameter logic [15:0]    IDLE_PATTERN = 16'h0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [DIGITS_W*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]          grant,
  output logic [DIGITS_W-1:0]         digits,
  output logic [DP_W-1:0]             decimal_points,
  output logic [1:0]                  active_idx
);
  state_t                r_state;
  logic [HOLD_WIDTH-1:0] r_hold;
  logic [1:0]            r_last;
  logic [1:0]            r_idx;
  logic [NUM_REQ-1:0]    r_grant;
  logic [DIGITS_W-1:0]   r_digits;
  logic [DP_W-1:0]       r_dp;
  logic                  w_found;
  logic [1:0]            w_win;
  logic                  w_arb;
  logic [NUM_REQ-1:0]    w_onehot;
  logic [DIGITS_W-1:0]   w_win_data;
  logic [DIGITS_W-1:0]   w_act_data;

  display_arbiter_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req  (req),
    .last (r_last),
    .found(w_found),
    .idx  (w_win)
  );

  assign w_arb      = (r_state == ST_IDLE) || (r_hold == '0);
  assign w_onehot   = NUM_REQ'(1) << w_win;
  assign w_win_data = data[DIGITS_W*int'(w_win) +: DIGITS_W];
  assign w_act_data = data[DIGITS_W*int'(r_idx) +: DIGITS_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_hold   <= '0;
      r_last   <= 2'(NUM_REQ - 1);
      r_idx    <= '0;
      r_grant  <= '0;
      r_digits <= IDLE_PATTERN;
      r_dp     <= '0;
    end else if (w_arb) begin
      if (w_found) begin
        r_state  <= ST_SHOW;
        r_hold   <= HOLD_WIDTH'(HOLD_CYCLES - 1);
        r_last   <= w_win;
        r_idx    <= w_win;
        r_grant  <= w_onehot;
        r_digits <= w_win_data;
        r_dp     <= DP_W'(w_onehot);
      end else begin
        r_state  <= ST_IDLE;
        r_idx    <= '0;
        r_grant  <= '0;
        r_digits <= IDLE_PATTERN;
        r_dp     <= '0;
      end
    end else begin
      // Grant is held for the full period; a dropped request only freezes the digits.
      r_hold <= r_hold - 1'b1;
      if (req[r_idx]) r_digits <= w_act_data;
    end
  end

  assign grant          = r_grant;
  assign digits         = r_digits;
  assign decimal_points = r_dp;
  assign active_idx     = r_idx;
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed vectors with a scoreboard queue checked by an independent monitor.
module tb_display_arbiter;
  typedef struct packed {
    logic [3:0]  g;
    logic [15:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] data = '0;
  logic [3:0]  grant;
  logic [15:0] digits;
  logic [3:0]  decimal_points;
  logic [1:0]  active_idx;
  logic [15:0] d [4];
  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;

  display_arbiter #(
    .NUM_REQ(4), .HOLD_CYCLES(4), .HOLD_WIDTH(3), .IDLE_PATTERN(16'h0000)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .grant(grant),
    .digits(digits), .decimal_points(decimal_points), .active_idx(active_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] oh2i(input logic [3:0] g);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("grant", 16'(grant), 16'(e.g));
      check("digits", digits, e.d);
      check("decimal_points", 16'(decimal_points), 16'(e.g));
      check("active_idx", 16'(active_idx), 16'(oh2i(e.g)));
    end
  end

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg, input logic [15:0] ed);
    @(negedge clk);
    reset = r;
    req = rq;
    data = {d[3], d[2], d[1], d[0]};
    q.push_back('{g: eg, d: ed});
  endtask

  initial begin
    d[0] = 16'h0A0A; d[1] = 16'h1234; d[2] = 16'h2C2C; d[3] = 16'h3333;
    repeat (3) step(1'b1, 4'b1111, 4'b0000, 16'h0000);
    step(1'b0, 4'b1111, 4'b0001, 16'h0A0A);
    step(1'b1, 4'b0000, 4'b0000, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) d[1] = 16'hBEEF;
      step(1'b0, 4'b0010, 4'b0010, (i < 10) ? 16'h1234 : 16'hBEEF);
    end
    d[1] = 16'h1234;
    step(1'b1, 4'b0000, 4'b0000, 16'h0000);
    for (int i = 0; i < 16; i++)
      step(1'b0, 4'b0101, ((i / 4) % 2) ? 4'b0100 : 4'b0001, ((i / 4) % 2) ? 16'h2C2C : 16'h0A0A);
    step(1'b1, 4'b0000, 4'b0000, 16'h0000);
    step(1'b0, 4'b0010, 4'b0010, 16'h1234);
    d[1] = 16'h5555;
    repeat (3) step(1'b0, 4'b0000, 4'b0010, 16'h1234);
    step(1'b0, 4'b0000, 4'b0000, 16'h0000);
    d[1] = 16'h1234;
    step(1'b1, 4'b0000, 4'b0000, 16'h0000);
    step(1'b0, 4'b1000, 4'b1000, 16'h3333);
    repeat (3) step(1'b0, 4'b1001, 4'b1000, 16'h3333);
    repeat (2) step(1'b0, 4'b1001, 4'b0001, 16'h0A0A);
    step(1'b1, 4'b0000, 4'b0000, 16'h0000);
    repeat (4) step(1'b0, 4'b0101, 4'b0001, 16'h0A0A);
    repeat (2) step(1'b0, 4'b0101, 4'b0100, 16'h2C2C);
    step(1'b1, 4'b0101, 4'b0000, 16'h0000);
    step(1'b0, 4'b0101, 4'b0001, 16'h0A0A);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
